// File: rtl/vga_timing_pkg.sv
// Shared timing constants and decode helpers for the VGA sync generator.
// Default numbers describe SVGA 800x600@60 with a 40 MHz pixel rate.
package vga_timing_pkg;

  // Width of both position counters; large enough for totals up to 2048.
  localparam int CNT_W     = 11;
  localparam int MAX_TOTAL = 2048;

  // Horizontal timing in pixels.
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BACK   = 88;
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FRONT  = 40;
  localparam int SVGA_H_TOTAL  = SVGA_H_SYNC + SVGA_H_BACK + SVGA_H_ACTIVE + SVGA_H_FRONT;

  // Vertical timing in lines.
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BACK   = 23;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FRONT  = 1;
  localparam int SVGA_V_TOTAL  = SVGA_V_SYNC + SVGA_V_BACK + SVGA_V_ACTIVE + SVGA_V_FRONT;

  // Which part of a line (or frame) a position falls in, in scan order.
  typedef enum logic [1:0] {
    SEG_SYNC   = 2'd0,
    SEG_BACK   = 2'd1,
    SEG_ACTIVE = 2'd2,
    SEG_FRONT  = 2'd3
  } axis_seg_e;

  // Classify a position along one axis; the front porch is whatever is left.
  function automatic axis_seg_e seg_of(input int pos, input int sync_w,
                                       input int back_w, input int active_w);
    axis_seg_e seg;
    if (pos < sync_w)
      seg = SEG_SYNC;
    else if (pos < sync_w + back_w)
      seg = SEG_BACK;
    else if (pos < sync_w + back_w + active_w)
      seg = SEG_ACTIVE;
    else
      seg = SEG_FRONT;
    return seg;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One axis of the raster: a wrapping position counter plus its registered
// sync and active-area decode. Used once for lines and once for frames.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int SYNC   = SVGA_H_SYNC,
  parameter int BACK   = SVGA_H_BACK,
  parameter int ACTIVE = SVGA_H_ACTIVE,
  parameter int FRONT  = SVGA_H_FRONT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sync_n,
  output logic             in_active,
  output logic             wrap
);

  localparam int TOTAL = SYNC + BACK + ACTIVE + FRONT;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  // Decoded values at position 0, so reset leaves outputs consistent with count.
  localparam logic RST_SYNC_N    = (seg_of(0, SYNC, BACK, ACTIVE) != SEG_SYNC);
  localparam logic RST_IN_ACTIVE = (seg_of(0, SYNC, BACK, ACTIVE) == SEG_ACTIVE);

  if (TOTAL < 1 || TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("vga_axis_counter: total %0d outside 1..%0d", TOTAL, MAX_TOTAL);
  end

  logic [CNT_W-1:0] count_nxt;
  logic             at_last;
  axis_seg_e        seg_nxt;

  assign at_last = (count == LAST);

  // Wrap strobe is combinational so the next axis can advance on the same edge.
  assign wrap = inc && at_last;

  // Next position and its segment; decode runs on the next value so the
  // registered flags line up with the registered count.
  always_comb begin
    count_nxt = count;
    if (inc) begin
      if (at_last)
        count_nxt = '0;
      else
        count_nxt = count + 1'b1;
    end
    seg_nxt = seg_of(int'(count_nxt), SYNC, BACK, ACTIVE);
  end

  // Position and decoded flags update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      sync_n    <= RST_SYNC_N;
      in_active <= RST_IN_ACTIVE;
    end else begin
      count     <= count_nxt;
      sync_n    <= (seg_nxt != SEG_SYNC);
      in_active <= (seg_nxt == SEG_ACTIVE);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate prescaler, horizontal and vertical
// position counters, active-low syncs, active-area flag and frame pulse.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC   = SVGA_H_SYNC,
  parameter int H_BACK   = SVGA_H_BACK,
  parameter int H_ACTIVE = SVGA_H_ACTIVE,
  parameter int H_FRONT  = SVGA_H_FRONT,
  parameter int V_SYNC   = SVGA_V_SYNC,
  parameter int V_BACK   = SVGA_V_BACK,
  parameter int V_ACTIVE = SVGA_V_ACTIVE,
  parameter int V_FRONT  = SVGA_V_FRONT,
  parameter int DIV      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] c1,
  output logic [CNT_W-1:0] c2,
  output logic             hsync,
  output logic             vsync,
  output logic             ready,
  output logic             frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(DIV - 1);

  if (DIV < 1) begin : g_bad_div
    $error("vga_sync_gen: DIV must be at least 1, got %0d", DIV);
  end

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("vga_sync_gen: totals %0d x %0d exceed %0d", H_TOTAL, V_TOTAL, MAX_TOTAL);
  end

  logic [PW-1:0] pcnt;
  logic          tick;
  logic          h_wrap;
  logic          v_wrap;
  logic          h_active;
  logic          v_active;

  // One pixel step every DIV enabled clocks; with DIV=1 this is just en.
  assign tick = en && (pcnt == PLAST);

  // Prescaler holds its phase while disabled so a pause does not shorten a pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pcnt <= '0;
    else if (en)
      pcnt <= (pcnt == PLAST) ? '0 : pcnt + 1'b1;
  end

  vga_axis_counter #(
    .SYNC   (H_SYNC),
    .BACK   (H_BACK),
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT)
  ) u_h_axis (
    .clk       (clk),
    .rst       (rst),
    .inc       (tick),
    .count     (c1),
    .sync_n    (hsync),
    .in_active (h_active),
    .wrap      (h_wrap)
  );

  // The line counter only steps when the pixel counter wraps on a tick.
  vga_axis_counter #(
    .SYNC   (V_SYNC),
    .BACK   (V_BACK),
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT)
  ) u_v_axis (
    .clk       (clk),
    .rst       (rst),
    .inc       (h_wrap),
    .count     (c2),
    .sync_n    (vsync),
    .in_active (v_active),
    .wrap      (v_wrap)
  );

  // Both axis flags are already registered against the current counters.
  assign ready = h_active && v_active;

  // Frame pulse marks the cycle in which the counters sit freshly at (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      frame_start <= 1'b0;
    else
      frame_start <= v_wrap;
  end

endmodule
